// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// Holds the sequencer state encoding, the grant codes used by the
// round-robin selector, and the word stride used when stepping bursts.
package dmem_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CPU_ACC = 3'd1,
    S_CPU_ACK = 3'd2,
    S_IP_ACC  = 3'd3,
    S_IP_DONE = 3'd4
  } state_e;

  typedef enum logic {
    GRANT_CPU = 1'b0,
    GRANT_IP  = 1'b1
  } grant_e;

  // Byte distance between consecutive words of a burst.
  localparam int unsigned WORD_STRIDE = 4;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin selector between the CPU and the IP accelerator.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   req_cpu_i   - CPU is requesting
//   req_ip_i    - IP is requesting
//   take_i      - the sequencer is able to accept a grant this cycle
//   valid_o     - at least one side is requesting
//   grant_o     - side selected this cycle
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_cpu_i,
  input  logic   req_ip_i,
  input  logic   take_i,
  output logic   valid_o,
  output grant_e grant_o
);

  grant_e last_q;

  // On a tie the side that was not served last wins.
  always_comb begin
    valid_o = req_cpu_i | req_ip_i;
    grant_o = GRANT_CPU;
    if (req_cpu_i && req_ip_i) begin
      grant_o = (last_q == GRANT_IP) ? GRANT_CPU : GRANT_IP;
    end else if (req_ip_i) begin
      grant_o = GRANT_IP;
    end
  end

  // Starting from IP makes the CPU win the first tie after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= GRANT_IP;
    end else if (take_i && valid_o) begin
      last_q <= grant_o;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter and sequencer sharing the data-memory port between the CPU
// (single-word accesses) and the IP accelerator (1-16 word bursts).
// Ports:
//   clk, rst                          - clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata             - CPU request fields (sampled in IDLE)
//   cpu_ack, cpu_rdata                - CPU completion pulse and read data
//   ip_req/we/addr/len/wdata          - IP burst request, ip_wdata per beat
//   ip_beat, ip_rvalid, ip_rdata      - per-beat strobe and read data return
//   ip_done                           - pulse after the last beat
//   mem_rw/ena/addr/wdata, mem_rdata  - memory port
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ip_req,
  input  logic              ip_we,
  input  logic [ADDR_W-1:0] ip_addr,
  input  logic [LEN_W-1:0]  ip_len,
  input  logic [DATA_W-1:0] ip_wdata,
  output logic              ip_beat,
  output logic              ip_rvalid,
  output logic [DATA_W-1:0] ip_rdata,
  output logic              ip_done,
  output logic              mem_rw,
  output logic              mem_ena,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e              state_q, state_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   cpu_wdata_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    beat_q;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic [DATA_W-1:0]   ip_rdata_q;
  logic                ip_rvalid_q;
  logic                in_idle;
  logic                arb_valid;
  grant_e              arb_grant;
  logic [ADDR_W-1:0]   beat_addr;

  assign in_idle = (state_q == S_IDLE);

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_cpu_i (cpu_req),
    .req_ip_i  (ip_req),
    .take_i    (in_idle),
    .valid_o   (arb_valid),
    .grant_o   (arb_grant)
  );

  // Adding a multiple of four keeps the low two address bits intact;
  // the sum wraps naturally at the address width.
  assign beat_addr = addr_q + (ADDR_W'(beat_q) * ADDR_W'(WORD_STRIDE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cpu_ack   = 1'b0;
    ip_beat   = 1'b0;
    ip_done   = 1'b0;
    mem_rw    = 1'b0;
    mem_ena   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          state_d = (arb_grant == GRANT_CPU) ? S_CPU_ACC : S_IP_ACC;
        end
      end
      S_CPU_ACC: begin
        mem_addr = addr_q;
        if (we_q) begin
          mem_rw    = 1'b1;
          mem_wdata = cpu_wdata_q;
        end else begin
          mem_ena = 1'b1;
        end
        state_d = S_CPU_ACK;
      end
      S_CPU_ACK: begin
        cpu_ack = 1'b1;
        state_d = S_IDLE;
      end
      S_IP_ACC: begin
        ip_beat  = 1'b1;
        mem_addr = beat_addr;
        // Burst write data is streamed straight from the accelerator.
        if (we_q) begin
          mem_rw    = 1'b1;
          mem_wdata = ip_wdata;
        end else begin
          mem_ena = 1'b1;
        end
        if (beat_q == len_q) begin
          state_d = S_IP_DONE;
        end
      end
      S_IP_DONE: begin
        ip_done = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request fields are captured on grant; the address register is shared
  // because only one side owns the port at a time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      cpu_wdata_q <= '0;
      len_q       <= '0;
      beat_q      <= '0;
    end else if (in_idle && arb_valid) begin
      if (arb_grant == GRANT_CPU) begin
        we_q        <= cpu_we;
        addr_q      <= cpu_addr;
        cpu_wdata_q <= cpu_wdata;
      end else begin
        we_q   <= ip_we;
        addr_q <= ip_addr;
        len_q  <= ip_len;
        beat_q <= '0;
      end
    end else if (state_q == S_IP_ACC && beat_q != len_q) begin
      beat_q <= beat_q + LEN_W'(1);
    end
  end

  // Read data is registered so it appears one cycle after the access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rdata_q <= '0;
      ip_rdata_q  <= '0;
      ip_rvalid_q <= 1'b0;
    end else begin
      ip_rvalid_q <= (state_q == S_IP_ACC) && !we_q;
      if (state_q == S_CPU_ACC && !we_q) begin
        cpu_rdata_q <= mem_rdata;
      end
      if (state_q == S_IP_ACC && !we_q) begin
        ip_rdata_q <= mem_rdata;
      end
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign ip_rdata  = ip_rdata_q;
  assign ip_rvalid = ip_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed CPU vector table, directed
// burst/arbitration/wrap/reset sequences, then randomized traffic checked
// against a transaction-level reference model.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic        ip_req, ip_we;
  logic [31:0] ip_addr, ip_wdata, ip_rdata;
  logic [3:0]  ip_len;
  logic        ip_beat, ip_rvalid, ip_done;
  logic        mem_rw, mem_ena;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ip_req(ip_req), .ip_we(ip_we), .ip_addr(ip_addr), .ip_len(ip_len), .ip_wdata(ip_wdata),
    .ip_beat(ip_beat), .ip_rvalid(ip_rvalid), .ip_rdata(ip_rdata), .ip_done(ip_done),
    .mem_rw(mem_rw), .mem_ena(mem_ena), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Clock generation, 10 time-unit period.
  always begin
    clk = 1'b0; #5;
    clk = 1'b1; #5;
  end

  // Byte-wide big-endian memory seen by the DUT (256 bytes, aliased).
  logic [7:0] envMem [256];
  logic       memClear;

  assign mem_rdata = {envMem[mem_addr[7:0]], envMem[mem_addr[7:0] + 8'd1],
                      envMem[mem_addr[7:0] + 8'd2], envMem[mem_addr[7:0] + 8'd3]};

  // Synchronous write port of the environment memory.
  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 256; i++) envMem[i] <= 8'h00;
    end else if (mem_rw) begin
      for (int i = 0; i < 4; i++) envMem[mem_addr[7:0] + 8'(i)] <= mem_wdata[31-8*i -: 8];
    end
  end

  // Reference model: one record per expected DUT cycle.
  typedef struct packed {
    logic        idle;
    logic        cpuAck;
    logic        setCpu;
    logic [31:0] cpuRdata;
    logic        ipBeat;
    logic        ipRvalid;
    logic [31:0] ipRdata;
    logic        ipDone;
    logic        memRw;
    logic        memEna;
    logic        wdataFromIp;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
  } cyc_t;

  cyc_t        expQ[$];
  cyc_t        cur, nxt;
  logic [7:0]  refMem [256];
  logic        lastWasCpu;
  logic [31:0] heldCpu, heldIp;

  // Snapshot of DUT outputs taken at the falling edge of the last cycle.
  logic [31:0] sAck, sCpuRdata, sBeat, sRvalid, sIpRdata, sDone, sRw, sEna, sAddr, sWdata;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
  } cpuVec_t;

  cpuVec_t cpuVecs [6];

  function automatic cyc_t idleCyc();
    cyc_t c;
    c = '0;
    c.idle = 1'b1;
    return c;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {refMem[b], refMem[b + 8'd1], refMem[b + 8'd2], refMem[b + 8'd3]};
  endfunction

  task automatic refWrite(input logic [31:0] a, input logic [31:0] d);
    logic [7:0] b;
    b = a[7:0];
    for (int i = 0; i < 4; i++) refMem[b + 8'(i)] = d[31-8*i -: 8];
  endtask

  task automatic modelReset();
    expQ.delete();
    nxt        = idleCyc();
    lastWasCpu = 1'b0;
    heldCpu    = 32'h0;
    heldIp     = 32'h0;
  endtask

  // Expands a granted request into its expected cycles.
  task automatic planTransaction();
    logic        pickCpu;
    cyc_t        c;
    logic [31:0] a;
    pickCpu = (cpu_req && ip_req) ? !lastWasCpu : cpu_req;
    lastWasCpu = pickCpu;
    if (pickCpu) begin
      c = idleCyc(); c.idle = 1'b0;
      c.memAddr = cpu_addr; c.memRw = cpu_we; c.memEna = !cpu_we;
      c.memWdata = cpu_we ? cpu_wdata : 32'h0;
      expQ.push_back(c);
      c = idleCyc(); c.idle = 1'b0; c.cpuAck = 1'b1;
      if (cpu_we) refWrite(cpu_addr, cpu_wdata);
      else begin c.setCpu = 1'b1; c.cpuRdata = refRead(cpu_addr); end
      expQ.push_back(c);
    end else begin
      for (int i = 0; i <= int'(ip_len); i++) begin
        c = idleCyc(); c.idle = 1'b0;
        a = ip_addr + 32'(4 * i);
        c.ipBeat = 1'b1; c.memAddr = a; c.memRw = ip_we; c.memEna = !ip_we;
        c.wdataFromIp = ip_we;
        if (!ip_we && i > 0) begin c.ipRvalid = 1'b1; c.ipRdata = refRead(a - 32'd4); end
        expQ.push_back(c);
      end
      c = idleCyc(); c.idle = 1'b0; c.ipDone = 1'b1;
      if (!ip_we) begin c.ipRvalid = 1'b1; c.ipRdata = refRead(ip_addr + 32'(4 * int'(ip_len))); end
      expQ.push_back(c);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Runs one clock cycle: called just after a rising edge, drives inputs,
  // compares every output against the model, returns after the next edge.
  task automatic applyStimulus(input logic cReq, input logic cWe, input logic [31:0] cAddr,
                               input logic [31:0] cWdata, input logic iReq, input logic iWe,
                               input logic [31:0] iAddr, input logic [3:0] iLen,
                               input logic [31:0] iWdata);
    cpu_req = cReq; cpu_we = cWe; cpu_addr = cAddr; cpu_wdata = cWdata;
    ip_req = iReq; ip_we = iWe; ip_addr = iAddr; ip_len = iLen; ip_wdata = iWdata;
    cur = nxt;
    if (cur.wdataFromIp) begin
      cur.memWdata = iWdata;
      refWrite(cur.memAddr, iWdata);
    end
    if (cur.setCpu) heldCpu = cur.cpuRdata;
    if (cur.ipRvalid) heldIp = cur.ipRdata;
    @(negedge clk);
    sAck = 32'(cpu_ack); sCpuRdata = cpu_rdata; sBeat = 32'(ip_beat); sRvalid = 32'(ip_rvalid);
    sIpRdata = ip_rdata; sDone = 32'(ip_done); sRw = 32'(mem_rw); sEna = 32'(mem_ena);
    sAddr = mem_addr; sWdata = mem_wdata;
    checkOutput("cpu_ack", sAck, 32'(cur.cpuAck));
    checkOutput("cpu_rdata", sCpuRdata, heldCpu);
    checkOutput("ip_beat", sBeat, 32'(cur.ipBeat));
    checkOutput("ip_rvalid", sRvalid, 32'(cur.ipRvalid));
    checkOutput("ip_rdata", sIpRdata, heldIp);
    checkOutput("ip_done", sDone, 32'(cur.ipDone));
    checkOutput("mem_rw", sRw, 32'(cur.memRw));
    checkOutput("mem_ena", sEna, 32'(cur.memEna));
    checkOutput("mem_addr", sAddr, cur.memAddr);
    checkOutput("mem_wdata", sWdata, cur.memWdata);
    checkOutput("rw_ena_exclusive", 32'(mem_rw & mem_ena), 32'h0);
    if (cur.idle && (cReq || iReq)) planTransaction();
    nxt = (expQ.size() > 0) ? expQ.pop_front() : idleCyc();
    @(posedge clk); #1;
  endtask

  initial begin
    cpuVecs[0] = '{we: 1'b1, addr: 32'h10, wdata: 32'hDEADBEEF, expRdata: 32'h0};
    cpuVecs[1] = '{we: 1'b0, addr: 32'h10, wdata: 32'h0,        expRdata: 32'hDEADBEEF};
    cpuVecs[2] = '{we: 1'b1, addr: 32'h40, wdata: 32'h12345678, expRdata: 32'hDEADBEEF};
    cpuVecs[3] = '{we: 1'b0, addr: 32'h40, wdata: 32'h0,        expRdata: 32'h12345678};
    cpuVecs[4] = '{we: 1'b0, addr: 32'h41, wdata: 32'h0,        expRdata: 32'h34567800};
    cpuVecs[5] = '{we: 1'b0, addr: 32'h11, wdata: 32'h0,        expRdata: 32'hADBEEF00};

    rst = 1'b1; memClear = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    ip_req = 1'b0; ip_we = 1'b0; ip_addr = 32'h0; ip_len = 4'd0; ip_wdata = 32'h0;
    for (int i = 0; i < 256; i++) refMem[i] = 8'h00;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_cpu_ack", 32'(cpu_ack), 32'h0);
    checkOutput("reset_cpu_rdata", cpu_rdata, 32'h0);
    checkOutput("reset_ip_beat", 32'(ip_beat), 32'h0);
    checkOutput("reset_ip_rdata", ip_rdata, 32'h0);
    checkOutput("reset_mem_addr", mem_addr, 32'h0);
    checkOutput("reset_mem_strobes", 32'({mem_rw, mem_ena}), 32'h0);
    rst = 1'b0; memClear = 1'b0;

    // Tie after reset: CPU, then IP, then CPU again.
    applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, 32'h90, 4'd0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, 32'h90, 4'd0, 32'h0);
    checkOutput("tie1_cpu_addr", sAddr, 32'h80);
    checkOutput("tie1_no_beat", sBeat, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, 32'h90, 4'd0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, 32'h90, 4'd0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, 32'h90, 4'd0, 32'h0);
    checkOutput("tie2_ip_beat", sBeat, 32'h1);
    checkOutput("tie2_ip_addr", sAddr, 32'h90);
    applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, 32'h90, 4'd0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, 32'h90, 4'd0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 32'h90, 4'd0, 32'h0);
    checkOutput("tie3_cpu_addr", sAddr, 32'h80);
    checkOutput("tie3_no_beat", sBeat, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);

    // CPU single-access vector table; each access spans 3 cycles.
    for (int v = 0; v < 6; v++) begin
      applyStimulus(1'b1, cpuVecs[v].we, cpuVecs[v].addr, cpuVecs[v].wdata, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);
      checkOutput("cpu_idle_noack", sAck, 32'h0);
      applyStimulus(1'b1, cpuVecs[v].we, cpuVecs[v].addr, cpuVecs[v].wdata, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);
      checkOutput("cpu_acc_rw", sRw, 32'(cpuVecs[v].we));
      checkOutput("cpu_acc_ena", sEna, 32'(!cpuVecs[v].we));
      checkOutput("cpu_acc_addr", sAddr, cpuVecs[v].addr);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);
      checkOutput("cpu_ack_pulse", sAck, 32'h1);
      checkOutput("cpu_ack_rdata", sCpuRdata, cpuVecs[v].expRdata);
      checkOutput("cpu_ack_mem_idle", sRw | sEna, 32'h0);
    end

    // IP write burst of 4 words at 0x20.
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 4'd3, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h20, 4'd3, 32'(k));
      checkOutput("ipw_beat", sBeat, 32'h1);
      checkOutput("ipw_addr", sAddr, 32'h20 + 32'(4 * (k - 1)));
      checkOutput("ipw_wdata", sWdata, 32'(k));
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);
    checkOutput("ipw_done", sDone, 32'h1);
    checkOutput("ipw_beat_end", sBeat, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);
    checkOutput("ipw_done_once", sDone, 32'h0);

    // IP read burst of the same 4 words.
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 4'd3, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);
      checkOutput("ipr_rvalid", sRvalid, 32'(k > 1));
      checkOutput("ipr_done", sDone, 32'(k == 5));
      if (k > 1) checkOutput("ipr_rdata", sIpRdata, 32'(k - 1));
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);

    // Address wrap at the top of the address space.
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hFFFFFFFC, 4'd1, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);
    checkOutput("wrap_addr0", sAddr, 32'hFFFFFFFC);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);
    checkOutput("wrap_addr1", sAddr, 32'h00000000);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);

    // Reset on beat 2 of a 4-beat read burst with a CPU request pending.
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 4'd3, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h20, 4'd3, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h20, 4'd3, 32'h0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    ip_req = 1'b1;
    #2 rst = 1'b1;
    #1;
    checkOutput("rstmid_ip_beat", 32'(ip_beat), 32'h0);
    checkOutput("rstmid_ip_rvalid", 32'(ip_rvalid), 32'h0);
    checkOutput("rstmid_ip_rdata", ip_rdata, 32'h0);
    checkOutput("rstmid_cpu_rdata", cpu_rdata, 32'h0);
    checkOutput("rstmid_mem_addr", mem_addr, 32'h0);
    checkOutput("rstmid_mem_ena", 32'(mem_ena), 32'h0);
    @(posedge clk); #1;
    checkOutput("rstmid_ip_done", 32'(ip_done), 32'h0);
    rst = 1'b0;
    modelReset();
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 4'd3, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h20, 4'd3, 32'h0);
    checkOutput("rstmid_cpu_first", sAddr, 32'h10);
    checkOutput("rstmid_cpu_ena", sEna, 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);

    // Randomized traffic checked against the model.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                    4'($urandom_range(0, 15)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
